// File: rtl/cam_search_array.sv
// CAPP core: registered comparand/mask broadcast onto dual-rail mismatch lines plus a WORDS x WIDTH bit-cell array.
// Optional CAM_MATCH_COUNT_EN adds match_count (popcount of match_lines) and any_match outputs.
module cam_search_array #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned WORDS = 100
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [WIDTH-1:0]     comparand,
   input  logic [WIDTH-1:0]     mask,
   input  logic                 perform_search,
   input  logic [2*WIDTH-1:0]   write_lines,
   input  logic [WORDS-1:0]     word_select,
   output logic [2*WIDTH-1:0]   mismatch_lines,
   output logic [WORDS-1:0]     match_lines,
   output logic [WIDTH-1:0]     read_lines
`ifdef CAM_MATCH_COUNT_EN
   ,
   output logic [$clog2(WORDS+1)-1:0] match_count,
   output logic                       any_match
`endif
);

   logic [2*WIDTH-1:0] mismatch_q, mismatch_d;
   logic               active_q, active_d;
   logic [WIDTH-1:0]   cell_q [WORDS];
   logic [WIDTH-1:0]   cell_d [WORDS];
   logic [WIDTH-1:0]   set_v, clr_v;
   logic [WIDTH-1:0]   ones_line, zeros_line;

   always_comb begin
      mismatch_d = mismatch_q;
      active_d   = active_q;
      if (perform_search) begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            mismatch_d[2*i]   = mask[i] & comparand[i];
            mismatch_d[2*i+1] = mask[i] & ~comparand[i];
         end
         active_d = 1'b1;
      end
   end

   // A conflicting pair (both lines high) sets neither set_v nor clr_v, so the bit holds.
   always_comb begin
      set_v = '0;
      clr_v = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         set_v[i] = write_lines[2*i+1] & ~write_lines[2*i];
         clr_v[i] = write_lines[2*i] & ~write_lines[2*i+1];
      end
      for (int unsigned w = 0; w < WORDS; w++) begin
         cell_d[w] = word_select[w] ? ((cell_q[w] | set_v) & ~clr_v) : cell_q[w];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         mismatch_q <= '0;
         active_q   <= 1'b0;
         for (int unsigned w = 0; w < WORDS; w++) begin
            cell_q[w] <= '0;
         end
      end else begin
         mismatch_q <= mismatch_d;
         active_q   <= active_d;
         for (int unsigned w = 0; w < WORDS; w++) begin
            cell_q[w] <= cell_d[w];
         end
      end
   end

   always_comb begin
      ones_line  = '0;
      zeros_line = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         ones_line[i]  = mismatch_q[2*i];
         zeros_line[i] = mismatch_q[2*i+1];
      end
   end

   always_comb begin
      match_lines = '0;
      read_lines  = '0;
      for (int unsigned w = 0; w < WORDS; w++) begin
         match_lines[w] = active_q &
                          ~|((~cell_q[w] & ones_line) | (cell_q[w] & zeros_line));
         if (word_select[w]) begin
            read_lines = read_lines | cell_q[w];
         end
      end
   end

   assign mismatch_lines = mismatch_q;

`ifdef CAM_MATCH_COUNT_EN
   localparam int unsigned CNT_W = $clog2(WORDS+1);
   logic [CNT_W-1:0] cnt_v;

   always_comb begin
      cnt_v = '0;
      for (int unsigned w = 0; w < WORDS; w++) begin
         cnt_v = cnt_v + CNT_W'(match_lines[w]);
      end
      match_count = RST ? '0 : cnt_v;
      any_match   = ~RST & |match_lines;
   end
`endif

endmodule

// File: tb/tb_cam_search_array.sv
// Directed bench for cam_search_array: a search-key/array model checked every cycle plus literal anchors.
module tb_cam_search_array;
   localparam int W = 32;
   localparam int N = 100;

   logic           CLK = 1'b0;
   logic           RST = 1'b1;
   logic [W-1:0]   comparand = '0;
   logic [W-1:0]   mask = '0;
   logic           perform_search = 1'b0;
   logic [2*W-1:0] write_lines = '0;
   logic [N-1:0]   word_select = '0;
   logic [2*W-1:0] mismatch_lines;
   logic [N-1:0]   match_lines;
   logic [W-1:0]   read_lines;
`ifdef CAM_MATCH_COUNT_EN
   logic [$clog2(N+1)-1:0] match_count;
   logic                   any_match;
`endif

   cam_search_array #(.WIDTH(W), .WORDS(N)) dut (
      .CLK(CLK), .RST(RST), .comparand(comparand), .mask(mask),
      .perform_search(perform_search), .write_lines(write_lines),
      .word_select(word_select), .mismatch_lines(mismatch_lines),
      .match_lines(match_lines), .read_lines(read_lines)
`ifdef CAM_MATCH_COUNT_EN
      , .match_count(match_count), .any_match(any_match)
`endif
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;
   bit check_en = 1'b0;

   // Model: array contents plus the key/mask of the last search
   logic [W-1:0] m_cell [N];
   logic [W-1:0] m_cmp = '0;
   logic [W-1:0] m_msk = '0;
   bit           m_act = 1'b0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2*W-1:0] enc(input logic [W-1:0] v);
      logic [2*W-1:0] r;
      for (int i = 0; i < W; i++) begin
         r[2*i+1] = v[i];
         r[2*i]   = ~v[i];
      end
      return r;
   endfunction

   function automatic logic [2*W-1:0] exp_mm();
      logic [2*W-1:0] r;
      for (int i = 0; i < W; i++) begin
         r[2*i]   = m_msk[i] & m_cmp[i];
         r[2*i+1] = m_msk[i] & ~m_cmp[i];
      end
      return r;
   endfunction

   function automatic logic [N-1:0] exp_match();
      logic [N-1:0] r;
      for (int w = 0; w < N; w++) r[w] = m_act && (((m_cell[w] ^ m_cmp) & m_msk) == '0);
      return r;
   endfunction

   function automatic logic [W-1:0] exp_read();
      logic [W-1:0] r = '0;
      for (int w = 0; w < N; w++) if (word_select[w]) r |= m_cell[w];
      return r;
   endfunction

   function automatic int exp_count();
      int c = 0;
      logic [N-1:0] m = exp_match();
      for (int w = 0; w < N; w++) c += int'(m[w]);
      return c;
   endfunction

   task automatic model_edge();
      if (RST) begin
         for (int w = 0; w < N; w++) m_cell[w] = '0;
         m_cmp = '0; m_msk = '0; m_act = 1'b0;
      end else begin
         for (int w = 0; w < N; w++) begin
            if (word_select[w]) begin
               for (int i = 0; i < W; i++) begin
                  if (write_lines[2*i+1] && !write_lines[2*i]) m_cell[w][i] = 1'b1;
                  else if (write_lines[2*i] && !write_lines[2*i+1]) m_cell[w][i] = 1'b0;
               end
            end
         end
         if (perform_search) begin
            m_cmp = comparand; m_msk = mask; m_act = 1'b1;
         end
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      model_edge();
      #1;
   endtask

   always @(negedge CLK) begin
      if (check_en) begin
         chk("match_lines", 128'(match_lines), 128'(exp_match()));
         chk("mismatch_lines", 128'(mismatch_lines), 128'(exp_mm()));
         chk("read_lines", 128'(read_lines), 128'(exp_read()));
`ifdef CAM_MATCH_COUNT_EN
         chk("match_count", 128'(match_count), 128'(exp_count()));
         chk("any_match", 128'(any_match), 128'(exp_count() != 0));
`endif
      end
   end

   task automatic wr(input int w, input logic [W-1:0] v);
      word_select = '0; word_select[w] = 1'b1;
      write_lines = enc(v);
      tick();
      word_select = '0; write_lines = '0;
   endtask

   task automatic search(input logic [W-1:0] c, input logic [W-1:0] m);
      comparand = c; mask = m; perform_search = 1'b1;
      tick();
      perform_search = 1'b0;
   endtask

   task automatic pulse_reset();
      RST = 1'b1;
      tick();
      RST = 1'b0;
   endtask

   initial begin
      logic [N-1:0] all_ones;
      logic [2*W-1:0] wl;
      all_ones = '1;
      for (int w = 0; w < N; w++) m_cell[w] = '0;
      tick();
      tick();
      RST = 1'b0;
      check_en = 1'b1;

      // Reset state: nothing matches, lines low, every word reads 0
      chk("reset_match", 128'(match_lines), 128'(0));
      chk("reset_mismatch", 128'(mismatch_lines), 128'(0));
      word_select = '1;
      tick();
      chk("reset_read_all", 128'(read_lines), 128'(0));
      word_select = '0;

      // Write then read back
      wr(3, 32'd457);
      word_select[3] = 1'b1;
      tick();
      chk("read_w3", 128'(read_lines), 128'h1C9);
      word_select = '0;

      // Masked search over low 6 bits
      wr(5, 32'd9);
      wr(7, 32'd10);
      search(32'd457, 32'h3F);
      chk("mm_low12", 128'(mismatch_lines[11:0]), 128'hA69);
      chk("match_3_5_7", 128'({match_lines[7], match_lines[5], match_lines[3]}), 128'b011);
      chk("match_unwritten", 128'(match_lines[0]), 128'(0));
`ifdef CAM_MATCH_COUNT_EN
      chk("count_sc3", 128'(match_count), 128'd2);
      chk("any_sc3", 128'(any_match), 128'd1);
`endif

      // Key held when perform_search is low; match tracks later writes
      comparand = 32'hDEAD_BEEF; mask = '1;
      tick();
      chk("mm_hold", 128'(mismatch_lines[11:0]), 128'hA69);
      wr(5, 32'd10);
      chk("match5_after_write", 128'(match_lines[5]), 128'(0));

      // Search and write on the same edge
      comparand = 32'h55; mask = 32'hFF; perform_search = 1'b1;
      word_select = '0; word_select[9] = 1'b1; write_lines = enc(32'h55);
      tick();
      perform_search = 1'b0; word_select = '0; write_lines = '0;
      chk("match9_same_edge", 128'(match_lines[9]), 128'(1));

      // Parallel write to two words leaves neighbours alone
      word_select = '0; word_select[10] = 1'b1; word_select[11] = 1'b1;
      write_lines = enc(32'hABC);
      tick();
      write_lines = '0;
      tick();
      chk("read_w10_w11", 128'(read_lines), 128'hABC);
      word_select = '0; word_select[12] = 1'b1;
      tick();
      chk("read_w12", 128'(read_lines), 128'(0));
      word_select = '0;

      // Empty mask matches everything, reset clears it
      search(32'h1234_5678, 32'h0);
      chk("mask0_all", 128'(match_lines), 128'(all_ones));
      pulse_reset();
      chk("post_rst_match", 128'(match_lines), 128'(0));

      // Conflict writes hold the bit
      wr(2, 32'hFF);
      word_select[2] = 1'b1;
      wl = '0; wl[1:0] = 2'b11;
      write_lines = wl;
      tick();
      wl = '0; wl[17:16] = 2'b11;
      write_lines = wl;
      tick();
      write_lines = '0; word_select = '0;
      wr(4, 32'h100);
      word_select[2] = 1'b1; word_select[4] = 1'b1;
      tick();
      chk("read_conflict", 128'(read_lines), 128'h1FF);
      word_select = '0;

`ifdef CAM_MATCH_COUNT_EN
      pulse_reset();
      wr(3, 32'd457); wr(5, 32'd9); wr(7, 32'd10);
      search(32'd457, 32'h3F);
      chk("count_sc6", 128'(match_count), 128'd2);
      search(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("count_all1", 128'(match_count), 128'd0);
      chk("any_all1", 128'(any_match), 128'd0);
`endif

      tick();
      tick();
      check_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
